flipping_scheduler: RTL and testbench

FLIPPING_SCHEDULER -- requirements
Module: flipping_scheduler

---
 rtl/flipping_scheduler.sv | 131 +++++++++++++
 tb/tb_flipping_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flipping_scheduler.sv
// flipping_scheduler: issues activation vectors to an external 2-cycle flipping datapath
// and returns its results in order through a small result FIFO.
module flipping_scheduler #(
    parameter int N          = 16,
    parameter int M          = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         num_vectors,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M-1:0][N-1:0] in_act,
    output logic [M-1:0][N-1:0] dp_act,
    output logic [M-1:0]        dp_f,
    input  logic [M-1:0][N-1:0] dp_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M-1:0][N-1:0] out_data,
    output logic [M-1:0]        out_f,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [15:0]         flip_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(N + 1);
    localparam int FW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_num, r_issued, r_flip;
    logic [1:0]          r_mode, r_v, r_last;
    logic [M-1:0]        r_f1, r_f2, w_f;
    logic [M-1:0][N-1:0] r_mem_data [FIFO_DEPTH];
    logic [M-1:0]        r_mem_f [FIFO_DEPTH];
    logic                r_mem_last [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [AW:0]         r_cnt;
    logic [AW+1:0]       w_occ;
    logic [16:0]         w_fsum;
    logic                w_start, w_accept, w_last_in, w_push, w_pop;

    function automatic logic [PW-1:0] lane_ones(input logic [N-1:0] v);
        lane_ones = '0;
        for (int b = 0; b < N; b++) lane_ones = lane_ones + PW'(v[b]);
    endfunction

    function automatic logic [FW-1:0] flag_ones(input logic [M-1:0] v);
        flag_ones = '0;
        for (int b = 0; b < M; b++) flag_ones = flag_ones + FW'(v[b]);
    endfunction

    assign w_start   = r_state == IDLE && start;
    assign w_occ     = (AW+2)'(r_cnt) + (AW+2)'(r_v[0]) + (AW+2)'(r_v[1]);
    assign in_ready  = r_state == RUN && w_occ < (AW+2)'(FIFO_DEPTH);
    assign w_accept  = in_valid && in_ready;
    assign w_last_in = r_issued == r_num - 16'd1;
    assign w_push    = r_v[1];
    assign w_pop     = out_valid && out_ready;
    assign busy      = r_state == RUN || r_state == DRAIN;
    assign done      = r_state == DONE;
    assign flip_count = r_flip;

    // Mode 11 falls through to no-flip; auto flips only on a strict majority of ones.
    always_comb begin
        w_f = '0;
        for (int l = 0; l < M; l++)
            w_f[l] = r_mode == 2'b01 || (r_mode == 2'b10 && lane_ones(in_act[l]) > PW'(N / 2));
    end

    assign dp_f   = w_accept ? w_f : '0;
    assign dp_act = w_accept ? in_act : '0;
    assign w_fsum = {1'b0, r_flip} + 17'(flag_ones(dp_f));

    assign out_valid = r_cnt != '0;
    assign out_data  = out_valid ? r_mem_data[r_rptr] : '0;
    assign out_f     = out_valid ? r_mem_f[r_rptr] : '0;
    assign out_last  = out_valid && r_mem_last[r_rptr];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = start ? (num_vectors != 16'd0 ? RUN : DONE) : IDLE;
            RUN:   w_next = w_accept && w_last_in ? DRAIN : RUN;
            DRAIN: w_next = r_v == 2'b00 && r_cnt == '0 ? DONE : DRAIN;
            DONE:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_num    <= '0;
            r_mode   <= '0;
            r_issued <= '0;
            r_flip   <= '0;
            r_v      <= '0;
            r_last   <= '0;
            r_f1     <= '0;
            r_f2     <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_num    <= w_start ? num_vectors : r_num;
            r_mode   <= w_start ? mode : r_mode;
            r_issued <= w_start ? 16'd0 : w_accept ? r_issued + 16'd1 : r_issued;
            r_flip   <= w_start ? 16'd0 : w_accept ? (w_fsum[16] ? 16'hFFFF : w_fsum[15:0]) : r_flip;
            r_v      <= {r_v[0], w_accept};
            r_last   <= {r_last[0], w_accept && w_last_in};
            r_f1     <= dp_f;
            r_f2     <= r_f1;
            r_wptr   <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr   <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= dp_res;
            r_mem_f[r_wptr]    <= r_f2;
            r_mem_last[r_wptr] <= r_last[1];
        end
    end
endmodule

// File: tb/tb_flipping_scheduler.sv
// tb_flipping_scheduler: scoreboard bench for flipping_scheduler with a behavioural
// 2-cycle datapath that inverts each lane whose flip flag is set.
module tb_flipping_scheduler;
    localparam int N = 16;
    localparam int M = 16;

    typedef struct packed {
        logic [M-1:0][N-1:0] d;
        logic [M-1:0]        f;
        logic                l;
    } exp_t;

    logic                clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0]         num_vectors = '0;
    logic [1:0]          mode = '0;
    logic [M-1:0][N-1:0] in_act = '0;
    logic [M-1:0][N-1:0] dp_act, dp_res, out_data, r_d1, r_d2;
    logic [M-1:0]        dp_f, out_f, mf;
    logic                in_ready, out_valid, out_last, busy, done;
    logic [15:0]         flip_count;

    exp_t        sb[$];
    exp_t        me;
    int          n_checks = 0, n_pass = 0, cyc = 0;
    int          job_nv = 0, acc_idx = 0, acc_cnt = 0, exp_flip = 0, done_cnt = 0, pops = 0;
    int          first_acc = 0, first_pop = 0, last_pop = 0;
    logic [1:0]  job_mode = '0;
    logic        busy_seen = 1'b0, ov_seen = 1'b0;

    flipping_scheduler #(.N(N), .M(M), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
        .dp_act(dp_act), .dp_f(dp_f), .dp_res(dp_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_f(out_f),
        .out_last(out_last), .busy(busy), .done(done), .flip_count(flip_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [M-1:0][N-1:0] flip(input logic [M-1:0][N-1:0] a, input logic [M-1:0] f);
        for (int l = 0; l < M; l++) flip[l] = f[l] ? ~a[l] : a[l];
    endfunction

    function automatic logic [M-1:0] exp_f(input logic [M-1:0][N-1:0] a, input logic [1:0] md);
        for (int l = 0; l < M; l++)
            exp_f[l] = md == 2'b01 ? 1'b1 : md == 2'b10 ? ($countones(a[l]) > N / 2) : 1'b0;
    endfunction

    function automatic logic [M-1:0][N-1:0] vec(input int kind);
        for (int l = 0; l < M; l++)
            vec[l] = kind == 2 ? 16'h1234 : (kind == 1 && l % 4 == 0) ? 16'hFFFF :
                     (kind == 1 && l % 4 == 1) ? 16'h00FF : N'($urandom);
    endfunction

    // Behavioural datapath: two register stages, cleared by the shared reset.
    always @(posedge clk) begin
        if (!rst) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= flip(dp_act, dp_f);
            r_d2 <= r_d1;
        end
    end
    assign dp_res = r_d2;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) sb.delete();
        else begin
            if (in_valid && in_ready) begin
                mf = exp_f(in_act, job_mode);
                check("dp_act", dp_act, in_act);
                check("dp_f", dp_f, mf);
                sb.push_back('{d: flip(in_act, mf), f: mf, l: acc_idx == job_nv - 1});
                exp_flip = exp_flip + $countones(mf);
                if (exp_flip > 65535) exp_flip = 65535;
                if (acc_cnt == 0) first_acc = cyc;
                acc_cnt++;
                acc_idx++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_out", out_valid, 0);
                else begin
                    me = sb.pop_front();
                    check("out_data", out_data, me.d);
                    check("out_f", out_f, me.f);
                    check("out_last", out_last, me.l);
                end
                if (pops == 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
            if (done) done_cnt++;
            busy_seen |= busy;
            ov_seen |= out_valid;
        end
    end

    task automatic start_job(input int nv, input logic [1:0] md);
        job_nv = nv; job_mode = md; acc_idx = 0; acc_cnt = 0; exp_flip = 0;
        done_cnt = 0; pops = 0; busy_seen = 1'b0; ov_seen = 1'b0;
        start = 1'b1; num_vectors = 16'(nv); mode = md;
        @(posedge clk); #1;
        start = 1'b0; num_vectors = 16'hDEAD; mode = ~md;
    endtask

    task automatic feed(input int nv, input int kind);
        int sent, guard;
        logic ok;
        sent = 0;
        guard = 0;
        while (sent < nv && guard < 20000) begin
            in_valid = 1'b1;
            in_act = vec(kind);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) sent++;
            guard++;
        end
        in_valid = 1'b0;
        in_act = '0;
        check("feed_count", sent, nv);
    endtask

    task automatic finish_job(input string tag);
        int g;
        g = 0;
        while (done_cnt == 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_pops"}, pops, job_nv);
        check({tag, "_flips"}, flip_count, exp_flip);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_flip_count", flip_count, 0);
        check("rst_dp_f", dp_f, 0);
        check("rst_dp_act", dp_act, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        start_job(4, 2'b10);
        feed(4, 1);
        finish_job("auto");
        check("first_latency", first_pop - first_acc, 3);
        check("back_to_back", last_pop - first_pop, 3);

        start_job(8, 2'b10);
        out_ready = 1'b0;
        fork
            feed(8, 0);
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_accepted", acc_cnt, 4);
                check("stall_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        finish_job("stall");

        start_job(0, 2'b00);
        @(negedge clk);
        check("zero_done_pulse", done, 1);
        @(negedge clk);
        check("zero_done_clear", done, 0);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_out_valid_seen", ov_seen, 0);
        @(posedge clk); #1;

        start_job(3, 2'b01);
        feed(3, 2);
        finish_job("force");
        check("force_flip_count", flip_count, 48);

        start_job(2, 2'b01);
        out_ready = 1'b0;
        feed(2, 0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_flips", flip_count, 32);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_flips", flip_count, 0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_done", done_cnt, 0);
        start_job(5, 2'b10);
        feed(5, 0);
        finish_job("after_rst");

        start_job(5, 2'b10);
        fork
            feed(5, 0);
            begin
                @(posedge clk); #1;
                start = 1'b1; num_vectors = 16'd2; mode = 2'b01;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        finish_job("restart_ignored");

        start_job(4100, 2'b01);
        feed(4100, 0);
        finish_job("saturate");
        check("saturate_ffff", flip_count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1);
    end
endmodule
